// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared constants for the data-memory load/store unit.
//   WORD_LEN      : data/address width (32)
//   F3_*          : RV32I load/store width codes carried on req_funct3
//   state_t       : dmem_lsu controller states
//   f3_illegal    : width code not usable for the given direction
//   f3_misaligned : address low bits not naturally aligned for the width
package dmem_lsu_pkg;

   localparam int WORD_LEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // Unsigned variants only make sense for loads.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = we;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3)
         F3_W:         mis = (lo != 2'b00);
         F3_H, F3_HU:  mis = lo[0];
         default:      mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// lsu_lane: combinational byte/halfword lane logic shared by the load
// response path and the store read-modify-write path.
//   funct3      : width code of the latched request
//   byte_off    : low address bits (byte lane; bit 1 selects the halfword)
//   mem_word    : word returned by memory
//   st_half     : low 16 bits of store data
//   ld_data     : extracted and sign/zero-extended load result
//   merged_word : mem_word with the store lane replaced
// A word access ignores byte_off and uses the whole word.
module lsu_lane
   import dmem_lsu_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic [1:0]          byte_off,
   input  logic [WORD_LEN-1:0] mem_word,
   input  logic [15:0]         st_half,
   output logic [WORD_LEN-1:0] ld_data,
   output logic [WORD_LEN-1:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (byte_off)
         2'd0:    byte_sel = mem_word[7:0];
         2'd1:    byte_sel = mem_word[15:8];
         2'd2:    byte_sel = mem_word[23:16];
         default: byte_sel = mem_word[31:24];
      endcase
      half_sel = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

      case (funct3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ld_data = {24'h0, byte_sel};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ld_data = {16'h0, half_sel};
         default: ld_data = mem_word;
      endcase

      merged_word = mem_word;
      if (funct3 == F3_B) begin
         case (byte_off)
            2'd0:    merged_word[7:0]   = st_half[7:0];
            2'd1:    merged_word[15:8]  = st_half[7:0];
            2'd2:    merged_word[23:16] = st_half[7:0];
            default: merged_word[31:24] = st_half[7:0];
         endcase
      end else if (funct3 == F3_H) begin
         if (byte_off[1]) merged_word[31:16] = st_half;
         else             merged_word[15:0]  = st_half;
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a word-wide memory port with one cycle
// of read latency. Sub-word stores are done as read-modify-write.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only when idle)
//   req_we/req_funct3        : store flag and RV32I width code
//   req_addr/req_wdata       : byte address and store data
//   resp_valid/resp_err      : completion pulse, rejected-request flag
//   resp_rdata               : extended load data (0 for stores/errors)
//   mem_addr/mem_wen         : word-aligned address, word write enable
//   mem_wdata/mem_rdata      : word write data, read data (previous-edge addr)
// Build option: DMEM_LSU_MISALIGN_TRAP_EN rejects misaligned W/H/HU requests;
// without it the low address bits are simply ignored for those widths.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request, memory port quiet
// ST_READ  | word address driven, memory read in flight
// ST_MERGE | sub-word lane merged into read word and written back
// ST_WRITE | full-word store written
// ST_RESP  | load result (or error) returned
module dmem_lsu
   import dmem_lsu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [WORD_LEN-1:0] req_addr,
   input  logic [WORD_LEN-1:0] req_wdata,
   output logic                resp_valid,
   output logic                resp_err,
   output logic [WORD_LEN-1:0] resp_rdata,
   output logic [WORD_LEN-1:0] mem_addr,
   output logic                mem_wen,
   output logic [WORD_LEN-1:0] mem_wdata,
   input  logic [WORD_LEN-1:0] mem_rdata
);

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          f3_q, f3_d;
   logic [WORD_LEN-1:0] addr_q, addr_d;
   logic [WORD_LEN-1:0] wdata_q, wdata_d;
   logic                err_q, err_d;

   logic                accept;
   logic                bad_req;
   logic [WORD_LEN-1:0] ld_data;
   logic [WORD_LEN-1:0] merged_word;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   assign bad_req = f3_illegal(req_we, req_funct3) ||
                    f3_misaligned(req_funct3, req_addr[1:0]);
`else
   assign bad_req = f3_illegal(req_we, req_funct3);
`endif

   assign accept = req_valid && (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = bad_req;
               if (bad_req)
                  state_d = ST_RESP;
               else if (req_we && req_funct3 == F3_W)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ:  state_d = we_q ? ST_MERGE : ST_RESP;
         ST_MERGE: state_d = ST_IDLE;
         ST_WRITE: state_d = ST_IDLE;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   lsu_lane u_lane (
      .funct3      (f3_q),
      .byte_off    (addr_q[1:0]),
      .mem_word    (mem_rdata),
      .st_half     (wdata_q[15:0]),
      .ld_data     (ld_data),
      .merged_word (merged_word)
   );

   // Outputs decode straight from state so an async reset kills mem_wen at once.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_wen    = 1'b0;
      mem_wdata  = '0;
      mem_addr   = (state_q == ST_IDLE) ? '0 : {addr_q[WORD_LEN-1:2], 2'b00};
      case (state_q)
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !we_q) resp_rdata = ld_data;
         end
         ST_WRITE: begin
            resp_valid = 1'b1;
            mem_wen    = 1'b1;
            mem_wdata  = wdata_q;
         end
         ST_MERGE: begin
            resp_valid = 1'b1;
            mem_wen    = 1'b1;
            mem_wdata  = merged_word;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu with a word memory model,
// a table of directed vectors, reset and back-to-back sequences, and random
// traffic checked against a shadow-memory reference model.
module tb_dmem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   bit   [31:0] mem_arr [1024];
   bit   [31:0] ref_mem [1024];
   logic        pre_en;
   logic [9:0]  pre_idx;
   logic [31:0] pre_data;

   int n_cmp = 0;
   int n_fail = 0;

   dmem_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory, one-cycle read latency, read returns old data on same-address write.
   always @(posedge clk) begin
      if (pre_en) mem_arr[pre_idx] <= pre_data;
      else if (mem_wen) mem_arr[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr[11:2]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = byte_addr[11:2];
      pre_data = data;
      ref_mem[byte_addr[11:2]] = data;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // Reference: the architectural effect of one request on a word memory.
   function automatic void model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] exp_rdata, output logic exp_err,
                                 output int exp_cyc, output int exp_wen);
      int          idx = int'(addr[11:2]);
      logic [31:0] w = ref_mem[idx];
      logic [31:0] part;
      logic [31:0] mask;
      int          sh;
      logic        illegal = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4);
      logic        mis = 1'b0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      mis = (f3 == 2 && addr[1:0] != 0) || ((f3 == 1 || f3 == 5) && addr[0]);
`endif
      exp_rdata = 0;
      exp_err   = 0;
      exp_wen   = 0;
      if (illegal || mis) begin
         exp_err = 1;
         exp_cyc = 1;
         return;
      end
      if (!we) begin
         exp_cyc = 2;
         if (f3 == 0 || f3 == 4) begin
            part = (w >> (8 * addr[1:0])) & 32'hFF;
            exp_rdata = (f3 == 0 && part >= 128) ? (part | 32'hFFFF_FF00) : part;
         end else if (f3 == 1 || f3 == 5) begin
            part = (w >> (16 * addr[1])) & 32'hFFFF;
            exp_rdata = (f3 == 1 && part >= 32768) ? (part | 32'hFFFF_0000) : part;
         end else begin
            exp_rdata = w;
         end
      end else begin
         exp_wen = 1;
         if (f3 == 2) begin
            exp_cyc = 1;
            ref_mem[idx] = wdata;
         end else begin
            exp_cyc = 2;
            sh   = (f3 == 0) ? 8 * addr[1:0] : 16 * addr[1];
            mask = (f3 == 0) ? 32'hFF : 32'hFFFF;
            ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
         end
      end
   endfunction

   // One request from idle; reports response cycle (0 = none within budget).
   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int cyc, output int wen_n, output logic [31:0] maddr);
      @(negedge clk);
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_mem_addr", mem_addr, 32'd0);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      @(negedge clk);
      // Junk while busy must be ignored.
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      cyc   = 0;
      wen_n = 0;
      rdata = 32'hx;
      err   = 1'bx;
      maddr = 32'hx;
      for (int c = 1; c <= 6; c++) begin
         if (mem_wen) wen_n++;
         if (resp_valid) begin
            cyc   = c;
            rdata = resp_rdata;
            err   = resp_err;
            maddr = mem_addr;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_cyc;
      int          exp_wen;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] rd, maddr, e_rd;
      logic        er, e_er;
      int          cy, wn, e_cy, e_wn;
      int          op_i, last_acc, gap_exp, cyc_n;
      logic [31:0] exp_q[$];
      logic [31:0] b2b_data;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // ---------------- directed table ----------------
      poke(32'h100, 32'h8765_43A1);
      poke(32'h300, 32'h1122_3344);
      poke(32'h200, 32'h0);
      //          we    f3      addr        wdata          exp_rdata     err  cyc wen
      vecs[0]  = '{1'b0, 3'b000, 32'h100, 32'h0,         32'hFFFF_FFA1, 1'b0, 2, 0};
      vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,         32'h0000_0087, 1'b0, 2, 0};
      vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,         32'hFFFF_8765, 1'b0, 2, 0};
      vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,         32'h0000_43A1, 1'b0, 2, 0};
      vecs[4]  = '{1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1};
      vecs[5]  = '{1'b0, 3'b010, 32'h200, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0};
      vecs[6]  = '{1'b1, 3'b000, 32'h301, 32'hFFFF_FFAB, 32'h0,         1'b0, 2, 1};
      vecs[7]  = '{1'b1, 3'b001, 32'h302, 32'h1234_CDEF, 32'h0,         1'b0, 2, 1};
      vecs[8]  = '{1'b0, 3'b010, 32'h300, 32'h0,         32'hCDEF_AB44, 1'b0, 2, 0};
      vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,         32'h0,         1'b1, 1, 0};
      vecs[10] = '{1'b1, 3'b100, 32'h300, 32'h55,        32'h0,         1'b1, 1, 0};
      vecs[11] = '{1'b1, 3'b111, 32'h300, 32'h55,        32'h0,         1'b1, 1, 0};
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      vecs[12] = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         1'b1, 1, 0};
`else
      vecs[12] = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h8765_43A1, 1'b0, 2, 0};
`endif
      for (int i = 0; i < 13; i++) begin
         do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, cy, wn, maddr);
         chk($sformatf("vec%0d_cycle", i), cy, vecs[i].exp_cyc);
         chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_wen_count", i), wn, vecs[i].exp_wen);
         if (!vecs[i].exp_err)
            chk($sformatf("vec%0d_mem_addr", i), maddr, {vecs[i].addr[31:2], 2'b00});
         if (i == 6) chk("sb_word_0x300", mem_arr[32'h300 >> 2], 32'h1122_AB44);
         if (i == 7) chk("sh_word_0x300", mem_arr[32'h300 >> 2], 32'hCDEF_AB44);
      end
      chk("sw_word_0x200", mem_arr[32'h200 >> 2], 32'hDEAD_BEEF);
      chk("err_no_write_0x300", mem_arr[32'h300 >> 2], 32'hCDEF_AB44);
      for (int i = 0; i < 13; i++) ref_mem[vecs[i].addr[11:2]] = mem_arr[vecs[i].addr[11:2]];

      // ---------------- reset while SB is in READ ----------------
      poke(32'h500, 32'hA5A5_A5A5);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h502; req_wdata = 32'h3C;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_sb_read_addr", mem_addr, 32'h500);
      chk("rst_sb_read_ready", {31'b0, req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_sb_wen_now", {31'b0, mem_wen}, 32'd0);
      chk("rst_sb_ready_now", {31'b0, req_ready}, 32'd1);
      chk("rst_sb_addr_now", mem_addr, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_sb_wen_hold", {31'b0, mem_wen}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_sb_ready_after", {31'b0, req_ready}, 32'd1);
      chk("rst_sb_word_kept", mem_arr[32'h500 >> 2], 32'hA5A5_A5A5);
      do_req(1'b0, 3'b010, 32'h500, 32'h0, rd, er, cy, wn, maddr);
      chk("rst_sb_reload", rd, 32'hA5A5_A5A5);

      // ---------------- back-to-back with req_valid held ----------------
      op_i = 0; last_acc = -1; gap_exp = 0; cyc_n = 0;
      b2b_data = $urandom;
      for (int t = 0; t < 300 && (op_i < 20 || exp_q.size() > 0); t++) begin
         @(negedge clk);
         cyc_n++;
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               chk("b2b_extra_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
               chk("b2b_rdata", resp_rdata, exp_q.pop_front());
               chk("b2b_err", {31'b0, resp_err}, 32'd0);
            end
         end
         if (req_ready) begin
            if (last_acc >= 0) chk("b2b_accept_gap", cyc_n - last_acc, gap_exp);
            if (op_i < 20) begin
               if (op_i % 2 == 0) b2b_data = $urandom;
               req_valid  = 1'b1;
               req_we     = (op_i % 2 == 0);
               req_funct3 = 3'b010;
               req_addr   = 32'h600 + 32'(4 * ((op_i / 2) % 4));
               req_wdata  = b2b_data;
               model(req_we, req_funct3, req_addr, req_wdata, e_rd, e_er, e_cy, e_wn);
               exp_q.push_back(e_rd);
               gap_exp  = req_we ? 2 : 3;
               last_acc = cyc_n;
               op_i++;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_ops_issued", op_i, 20);
      chk("b2b_resp_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // ---------------- random traffic vs reference model ----------------
      for (int i = 0; i < 16; i++) poke(32'h400 + 32'(4 * i), $urandom);
      for (int n = 0; n < 300; n++) begin
         logic        r_we;
         logic [2:0]  r_f3;
         logic [31:0] r_addr, r_wd;
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = 32'h400 + $urandom_range(0, 63);
         r_wd   = $urandom;
         model(r_we, r_f3, r_addr, r_wd, e_rd, e_er, e_cy, e_wn);
         do_req(r_we, r_f3, r_addr, r_wd, rd, er, cy, wn, maddr);
         chk("rnd_cycle", cy, e_cy);
         chk("rnd_err", {31'b0, er}, {31'b0, e_er});
         chk("rnd_rdata", rd, e_rd);
         chk("rnd_wen_count", wn, e_wn);
         if (!e_er) chk("rnd_mem_addr", maddr, {r_addr[31:2], 2'b00});
         chk("rnd_mem_word", mem_arr[r_addr[11:2]], ref_mem[r_addr[11:2]]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
